mem_router: RTL and testbench
=============================

// Module: mem_router
// PURPOSE
//  Parametrised CPU-to-on-chip-memory router: decodes each 8-bit CPU access against NREG base/mask regions,
//  drives one region's write strobe, waits a per-region number of cycles, returns read data with a ready pulse.
//  Sits between core and the block RAMs (base memory, text/font, BIOS, ...); replaces the combinational decode
//  and adds wait states, an unmapped-access flag and a bankable graphics window.
// PARAMETERS
//  ADDR_W       20                 CPU address width
//  DATA_W       8                  data width
//  NREG         4                  number of regions
//  OUT_AW       18                 region-local address width
//  REGION_BASE  {A0000,F8000,B8000,00000}  NREG*ADDR_W packed base, region 0 in LSBs
//  REGION_MASK  {F0000,F8000,FE000,C0000}  NREG*ADDR_W packed compare mask
//  REGION_WAIT  {0,0,0,0}          NREG*4 packed extra wait cycles, 0..15
//  WIN_REG      3                  region index acting as graphics window
//  WIN_TARGET   0                  region the window is redirected into
//  UNMAP_DATA   8'hFF              read data for unmapped access
// PORTS
//  clock        in   1              system clock
//  reset        in   1              synchronous, active-high reset
//  cpu_req      in   1              access request, sampled in IDLE
//  cpu_we       in   1              1 = write
//  cpu_addr     in   ADDR_W         byte address
//  cpu_wdata    in   DATA_W         write data
//  cpu_rdata    out  DATA_W         read data, valid with cpu_ready, held until next ready
//  cpu_ready    out  1              one-cycle completion pulse
//  reg_addr     out  OUT_AW         region-local address, held for whole transaction
//  reg_wdata    out  DATA_W         write data to regions
//  reg_we       out  NREG           one-hot write strobe, one cycle
//  reg_rdata    in   NREG*DATA_W    region read data, 1-cycle RAM latency
//  win_enable   in   1              window redirect on (videomode decode done outside)
//  win_bank     in   OUT_AW-16      bank bits prepended to addr[15:0] in window
//  err_unmapped out  1              sticky: an unmapped access occurred
//  err_clr      in   1              clears err_unmapped
// BEHAVIOUR
//  Reset: state IDLE, cpu_ready=0, cpu_rdata=UNMAP_DATA, reg_we=0, reg_addr=0, reg_wdata=0, err_unmapped=0.
//  Match: region i hits when (cpu_addr & MASK_i) == BASE_i; lowest index wins on overlap; none -> unmapped.
//  Address: reg_addr = cpu_addr[OUT_AW-1:0] latched in IDLE.
//  IDLE: on cpu_req latch addr/wdata/region, load cnt=WAIT_i; write -> reg_we[i]=1 next cycle only. Go ACCESS.
//  ACCESS: RAM latency cycle; if cnt==0 -> DONE else -> WAIT.
//  WAIT: cnt decrements each cycle; at cnt==1 -> DONE.
//  DONE: cpu_rdata <= reg_rdata[i] (read), or unchanged (write); cpu_ready=1 for one cycle; -> IDLE.
//  Latency req->ready: 3+WAIT_i cycles; unmapped: 3 cycles, rdata=UNMAP_DATA, no reg_we, err_unmapped set.
//  cpu_req still high in IDLE after ready = new transaction; CPU drops req on the ready cycle.
//  Inputs other than reg_rdata ignored outside IDLE. reset mid-transaction: -> IDLE, pending write not issued
//  if not yet strobed, no ready. err_clr and new unmapped access in same cycle: set wins.
// CONFIGURATION
//  MEM_ROUTER_WINDOW_EN defined: hit on WIN_REG with win_enable=1 redirects to WIN_TARGET, reg_addr =
//  {win_bank, cpu_addr[15:0]}, wait = WAIT of WIN_TARGET; with win_enable=0 WIN_REG hit is unmapped.
//  Undefined: WIN_REG is an ordinary region; win_enable/win_bank ignored.
// STRUCTURE
//  mem_router_pkg: state encoding (IDLE, ACCESS, WAIT, DONE), default region base/mask constants,
//  function region_hit(addr, base, mask).
//  Sub-module mem_router_decode: combinational priority decoder -> hit, index, local address (window remap).
//  mem_router: FSM, wait counter, latches, error flag.
// TESTING
//  1 Read 0x01234, reg_rdata[0]=8'h5A, WAIT0=0 -> reg_addr=18'h01234, ready 3 cycles after req, rdata=5A.
//  2 Write 0xB8010 data 8'h41 -> reg_we=4'b0010 for one cycle, reg_addr[12:0]=13'h0010, reg_wdata=41.
//  3 WAIT2=5, read 0xF8000 -> ready 8 cycles after req; no other reg_we.
//  4 Read 0xC0000 -> rdata=8'hFF, err_unmapped=1 until err_clr pulse; no reg_we.
//  5 WINDOW_EN, win_enable=1, win_bank=2'b11, write 0xA1234 -> reg_we=4'b0001, reg_addr=18'h31234;
//    win_enable=0 same access -> unmapped.
//  6 reset asserted in WAIT of a read -> cpu_ready stays 0, state IDLE, next req served normally.

Source files
------------

// File: rtl/mem_router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_router_pkg
//  Description : Shared types and constants for the CPU-to-memory router.
//                FSM state encoding, the default region map and the region
//                match helper used by the decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Default map, region 0 in the LSBs:
  //   0: 00000-3FFFF base memory   1: B8000-B9FFF text/font
  //   2: F8000-FFFFF BIOS          3: A0000-AFFFF graphics window
  localparam logic [79:0] c_def_region_base = 80'hA0000_F8000_B8000_00000;
  localparam logic [79:0] c_def_region_mask = 80'hF0000_F8000_FE000_C0000;
  localparam logic [15:0] c_def_region_wait = 16'h0000;

  // Arguments are zero-extended to 32 bits so one helper serves any ADDR_W.
  function automatic logic region_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_router_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mem_router_decode
//  Description : Combinational priority decoder. Lowest matching region
//                index wins. Optional graphics-window redirect is compiled
//                in with MEM_ROUTER_WINDOW_EN.
//  Ports       : i_addr        CPU byte address
//                i_win_enable  window redirect enable
//                i_win_bank    bank bits prepended to i_addr[15:0] in window
//                o_hit         some region matched
//                o_idx         matched (possibly redirected) region index
//                o_laddr       region-local address
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_router_decode
  import mem_router_pkg::*;
#(
  parameter int                     ADDR_W      = 20,
  parameter int                     NREG        = 4,
  parameter int                     OUT_AW      = 18,
  parameter int                     IDX_W       = 2,
  parameter logic [NREG*ADDR_W-1:0] REGION_BASE = c_def_region_base,
  parameter logic [NREG*ADDR_W-1:0] REGION_MASK = c_def_region_mask,
  parameter int                     WIN_REG     = 3,
  parameter int                     WIN_TARGET  = 0
) (
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic                 i_win_enable,
  input  logic [OUT_AW-17:0]   i_win_bank,
  output logic                 o_hit,
  output logic [IDX_W-1:0]     o_idx,
  output logic [OUT_AW-1:0]    o_laddr
);

  logic              w_hit;
  logic [IDX_W-1:0]  w_idx;
  logic [OUT_AW-1:0] w_laddr;

  always_comb begin
    w_hit   = 1'b0;
    w_idx   = '0;
    w_laddr = i_addr[OUT_AW-1:0];
    // Scan from the top so the lowest matching index is the last assignment.
    for (int i = NREG - 1; i >= 0; i--) begin
      if (region_hit(32'(i_addr),
                     32'(REGION_BASE[i*ADDR_W +: ADDR_W]),
                     32'(REGION_MASK[i*ADDR_W +: ADDR_W]))) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
      end
    end
`ifdef MEM_ROUTER_WINDOW_EN
    // Window hits are redirected into the target RAM; with the window
    // disabled the window range is treated as unmapped.
    if (w_hit && (w_idx == IDX_W'(WIN_REG))) begin
      if (i_win_enable) begin
        w_idx   = IDX_W'(WIN_TARGET);
        w_laddr = {i_win_bank, i_addr[15:0]};
      end else begin
        w_hit = 1'b0;
      end
    end
`endif
  end

`ifndef MEM_ROUTER_WINDOW_EN
  // Window controls have no effect in this build.
  logic w_unused_win;
  assign w_unused_win = ^{i_win_enable, i_win_bank};
`endif

  assign o_hit   = w_hit;
  assign o_idx   = w_idx;
  assign o_laddr = w_laddr;

endmodule
`default_nettype wire

// File: rtl/mem_router.sv
`default_nettype none
// ============================================================================
//  Module      : mem_router
//  Description : CPU-to-on-chip-memory router. Decodes an 8-bit CPU access
//                against NREG base/mask regions, strobes the selected
//                region's write enable, inserts per-region wait states and
//                returns read data with a one-cycle ready pulse.
//                Optional feature macro: MEM_ROUTER_WINDOW_EN (bankable
//                graphics window redirect).
//  Ports       : clock, reset      clock, synchronous active-high reset
//                i_cpu_req/we/addr/wdata   CPU request (sampled in IDLE)
//                o_cpu_rdata/o_cpu_ready   CPU completion
//                o_reg_addr/wdata/we       region-side address, data, strobe
//                i_reg_rdata               region read data (1-cycle RAM)
//                i_win_enable/i_win_bank   graphics window control
//                o_err_unmapped/i_err_clr  sticky unmapped-access flag
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_router
  import mem_router_pkg::*;
#(
  parameter int                     ADDR_W      = 20,
  parameter int                     DATA_W      = 8,
  parameter int                     NREG        = 4,
  parameter int                     OUT_AW      = 18,
  parameter logic [NREG*ADDR_W-1:0] REGION_BASE = c_def_region_base,
  parameter logic [NREG*ADDR_W-1:0] REGION_MASK = c_def_region_mask,
  parameter logic [NREG*4-1:0]      REGION_WAIT = c_def_region_wait,
  parameter int                     WIN_REG     = 3,
  parameter int                     WIN_TARGET  = 0,
  parameter logic [DATA_W-1:0]      UNMAP_DATA  = 8'hFF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_cpu_req,
  input  logic                   i_cpu_we,
  input  logic [ADDR_W-1:0]      i_cpu_addr,
  input  logic [DATA_W-1:0]      i_cpu_wdata,
  output logic [DATA_W-1:0]      o_cpu_rdata,
  output logic                   o_cpu_ready,
  output logic [OUT_AW-1:0]      o_reg_addr,
  output logic [DATA_W-1:0]      o_reg_wdata,
  output logic [NREG-1:0]        o_reg_we,
  input  logic [NREG*DATA_W-1:0] i_reg_rdata,
  input  logic                   i_win_enable,
  input  logic [OUT_AW-17:0]     i_win_bank,
  output logic                   o_err_unmapped,
  input  logic                   i_err_clr
);

  localparam int c_idx_w = (NREG > 1) ? $clog2(NREG) : 1;

  logic               w_hit;
  logic [c_idx_w-1:0] w_idx;
  logic [OUT_AW-1:0]  w_laddr;
  logic [3:0]         w_wait;
  logic [NREG-1:0]    w_onehot;
  logic [DATA_W-1:0]  w_sel_rdata;

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic [c_idx_w-1:0] r_idx;
  logic               r_hit;
  logic               r_wr;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_ready;
  logic [OUT_AW-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [NREG-1:0]    r_we;
  logic               r_err;

  mem_router_decode #(
    .ADDR_W      (ADDR_W),
    .NREG        (NREG),
    .OUT_AW      (OUT_AW),
    .IDX_W       (c_idx_w),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK),
    .WIN_REG     (WIN_REG),
    .WIN_TARGET  (WIN_TARGET)
  ) u_decode (
    .i_addr       (i_cpu_addr),
    .i_win_enable (i_win_enable),
    .i_win_bank   (i_win_bank),
    .o_hit        (w_hit),
    .o_idx        (w_idx),
    .o_laddr      (w_laddr)
  );

  // Wait count of the decoded region and read data of the latched region.
  always_comb begin
    w_wait      = '0;
    w_sel_rdata = '0;
    for (int i = 0; i < NREG; i++) begin
      if (w_idx == c_idx_w'(i)) w_wait = REGION_WAIT[i*4 +: 4];
      if (r_idx == c_idx_w'(i)) w_sel_rdata = i_reg_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign w_onehot = NREG'(1) << w_idx;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_hit   <= 1'b0;
      r_wr    <= 1'b0;
      r_rdata <= UNMAP_DATA;
      r_ready <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= '0;
      r_err   <= 1'b0;
    end else begin
      // Strobe and ready are single-cycle pulses.
      r_we    <= '0;
      r_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_err_clr) r_err <= 1'b0;
          if (i_cpu_req) begin
            r_addr  <= w_laddr;
            r_wdata <= i_cpu_wdata;
            r_idx   <= w_idx;
            r_hit   <= w_hit;
            r_wr    <= i_cpu_we;
            r_cnt   <= w_hit ? w_wait : 4'd0;
            if (w_hit && i_cpu_we) r_we <= w_onehot;
            // Placed after the clear so a simultaneous new error wins.
            if (!w_hit) r_err <= 1'b1;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_state <= (r_cnt == 4'd0) ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (!r_wr) r_rdata <= r_hit ? w_sel_rdata : UNMAP_DATA;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cpu_rdata    = r_rdata;
  assign o_cpu_ready    = r_ready;
  assign o_reg_addr     = r_addr;
  assign o_reg_wdata    = r_wdata;
  assign o_reg_we       = r_we;
  assign o_err_unmapped = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_router
//  Description : Self-checking bench for mem_router. Region RAMs are modelled
//                as a fixed data pattern with one cycle of latency; expected
//                results come from a table-driven region map.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_router;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [19:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic [17:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic [3:0]  reg_we;
  logic [31:0] reg_rdata = '0;
  logic        win_en;
  logic [1:0]  win_bk;
  logic        err_unmapped;
  logic        err_clr;

  int checks   = 0;
  int failures = 0;

  // Region map: index 0..3
  int unsigned base_t[4] = '{32'h00000, 32'hB8000, 32'hF8000, 32'hA0000};
  int unsigned mask_t[4] = '{32'hC0000, 32'hFE000, 32'hF8000, 32'hF0000};
  int          wait_t[4] = '{0, 2, 5, 1};

  logic        exp_err   = 1'b0;
  logic [7:0]  exp_rdata = 8'hFF;

  always #5 clock = ~clock;

  mem_router #(
    .REGION_WAIT (16'h1520)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .i_cpu_req      (cpu_req),
    .i_cpu_we       (cpu_we),
    .i_cpu_addr     (cpu_addr),
    .i_cpu_wdata    (cpu_wdata),
    .o_cpu_rdata    (cpu_rdata),
    .o_cpu_ready    (cpu_ready),
    .o_reg_addr     (reg_addr),
    .o_reg_wdata    (reg_wdata),
    .o_reg_we       (reg_we),
    .i_reg_rdata    (reg_rdata),
    .i_win_enable   (win_en),
    .i_win_bank     (win_bk),
    .o_err_unmapped (err_unmapped),
    .i_err_clr      (err_clr)
  );

  // RAM content pattern per region and local address.
  function automatic logic [7:0] ramf(input int i, input logic [17:0] a);
    return 8'(int'(a[7:0]) + int'(a[15:8]) * 3 + int'(a[17:16]) * 7 + (i + 1) * 53);
  endfunction

  // One-cycle-latency RAM read for every region.
  always @(posedge clock) begin
    for (int i = 0; i < 4; i++) reg_rdata[i*8 +: 8] <= ramf(i, reg_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode from the region table.
  task automatic model(input logic [19:0] a, output bit hit, output int idx,
                       output logic [17:0] la);
    hit = 0;
    idx = 0;
    la  = a[17:0];
    for (int i = 3; i >= 0; i--) begin
      if ((32'(a) & mask_t[i]) == base_t[i]) begin
        hit = 1;
        idx = i;
      end
    end
`ifdef MEM_ROUTER_WINDOW_EN
    if (hit && idx == 3) begin
      if (win_en) begin
        idx = 0;
        la  = {win_bk, a[15:0]};
      end else begin
        hit = 0;
      end
    end
`endif
  endtask

  // Runs one access starting and ending on a negative clock edge.
  task automatic access(input logic we, input logic [19:0] a, input logic [7:0] wd,
                        input logic clr);
    bit          hit;
    int          idx;
    logic [17:0] la;
    int          lat;
    int          n;
    int          we_cnt;
    logic [3:0]  we_seen;
    logic [3:0]  exp_we;
    logic [7:0]  wd_at_we;
    bit          done;
    model(a, hit, idx, la);
    lat    = hit ? 3 + wait_t[idx] : 3;
    exp_we = (hit && we) ? 4'(1 << idx) : 4'd0;
    if (clr) exp_err = 1'b0;
    if (!hit) exp_err = 1'b1;
    if (!we) exp_rdata = hit ? ramf(idx, la) : 8'hFF;

    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    err_clr   = clr;
    @(posedge clock);
    #1;
    // Scramble everything the router must ignore outside IDLE.
    cpu_req   = 1'b0;
    err_clr   = 1'b0;
    cpu_we    = 1'($urandom);
    cpu_addr  = 20'($urandom);
    cpu_wdata = 8'($urandom);
    n = 1; we_cnt = 0; we_seen = '0; wd_at_we = '0; done = 0;
    while (!done && n < 40) begin
      @(negedge clock);
      if (reg_we != 4'd0) begin
        we_cnt++;
        we_seen  = we_seen | reg_we;
        wd_at_we = reg_wdata;
      end
      if (cpu_ready) done = 1;
      else begin
        @(posedge clock);
        n++;
      end
    end
    chk("latency", done ? n : 99, lat);
    chk("reg_addr", reg_addr, la);
    chk("reg_we", we_seen, exp_we);
    chk("we_count", we_cnt, (exp_we != 0) ? 1 : 0);
    if (exp_we != 0) chk("reg_wdata", wd_at_we, wd);
    chk("cpu_rdata", cpu_rdata, exp_rdata);
    chk("err", err_unmapped, exp_err);
    @(negedge clock);
    chk("ready_pulse", cpu_ready, 1'b0);
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    win_en = 1'b0; win_bk = 2'b00; err_clr = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_ready", cpu_ready, 1'b0);
    chk("rst_rdata", cpu_rdata, 8'hFF);
    chk("rst_we", reg_we, 4'd0);
    chk("rst_addr", reg_addr, 18'd0);
    chk("rst_wdata", reg_wdata, 8'd0);
    chk("rst_err", err_unmapped, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    // Directed accesses
    access(1'b0, 20'h01234, 8'h00, 1'b0);
    access(1'b1, 20'hB8010, 8'h41, 1'b0);
    access(1'b0, 20'hF8000, 8'h00, 1'b0);
    access(1'b0, 20'hA0F0F, 8'h00, 1'b0);
    access(1'b0, 20'hC0000, 8'h00, 1'b0);
    access(1'b1, 20'hC1234, 8'h77, 1'b0);
    access(1'b0, 20'h3FFFF, 8'h00, 1'b0);
    // Clear the sticky flag while idle.
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    exp_err = 1'b0;
    chk("err_clr", err_unmapped, 1'b0);
    // Clear and new unmapped access together: set wins.
    access(1'b0, 20'hC0010, 8'h00, 1'b1);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    exp_err = 1'b0;

`ifdef MEM_ROUTER_WINDOW_EN
    win_en = 1'b1; win_bk = 2'b11;
    access(1'b1, 20'hA1234, 8'h5C, 1'b0);
    access(1'b0, 20'hA1234, 8'h00, 1'b0);
    win_en = 1'b0;
    access(1'b1, 20'hA1234, 8'h5C, 1'b0);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    exp_err = 1'b0;
`else
    win_en = 1'b1; win_bk = 2'b11;
    access(1'b1, 20'hA1234, 8'h5C, 1'b0);
    win_en = 1'b0;
`endif

    // Reset while a long read sits in WAIT.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'hF8123;
    @(posedge clock);
    #1 cpu_req = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_err = 1'b0;
    exp_rdata = 8'hFF;
    begin
      int rdy_seen = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clock);
        if (cpu_ready) rdy_seen++;
      end
      chk("rst_mid_ready", rdy_seen, 0);
    end
    chk("rst_mid_rdata", cpu_rdata, 8'hFF);
    access(1'b0, 20'hF8123, 8'h00, 1'b0);

    // Randomized accesses across all regions and the unmapped hole.
    for (int t = 0; t < 40; t++) begin
      int          r;
      logic [19:0] a;
      r = $urandom_range(0, 4);
      if (r < 4) a = 20'(base_t[r] | ($urandom & ~mask_t[r]));
      else       a = 20'(32'hC0000 | ($urandom & 32'hFFFF));
      win_en = 1'($urandom);
      win_bk = 2'($urandom);
      access(1'($urandom), a, 8'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
